// File: rtl/vector_mem_responder_pkg.sv
// Shared types for the vector load/store request protocol and its memory-side responder.
package vector_mem_responder_pkg;

    localparam int REQUEST_COUNTER_WIDTH = 8;

    localparam logic [1:0] READ_REQ  = 2'd0;
    localparam logic [1:0] WRITE_REQ = 2'd1;

    typedef struct packed {
        logic                             vld;
        logic [1:0]                       access_type;
        logic [3:0]                       access_length;
        logic [REQUEST_COUNTER_WIDTH-1:0] access_id;
        logic [3:0]                       core_id;
        logic [31:0]                      addr;
        logic [7:0]                       byte_en;
        logic [63:0]                      data;
    } request_t;

    localparam int MEM_RSP_LATENCY_DEFAULT = 2;

    typedef enum logic {
        MR_INIT,
        MR_READY
    } mem_resp_state_t;

endpackage

// File: rtl/vector_mem_req_fifo.sv
// Request FIFO holding request_t entries; head is presented combinationally on rdata.
module vector_mem_req_fifo
    import vector_mem_responder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  request_t                      wdata,
    output request_t                      rdata,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    request_t         entries [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = entries[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            entries[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vector_mem_responder.sv
// Memory-side responder: zero-sweeps a local word memory, then services requests in order.
//   state    | meaning
//   MR_INIT  | writing zero to word[sweep_cnt], one word per cycle; no grants
//   MR_READY | serviceable; terminal until reset
module vector_mem_responder
    import vector_mem_responder_pkg::*;
#(
    parameter int MEM_DEPTH    = 1024,
    parameter int READ_LATENCY = MEM_RSP_LATENCY_DEFAULT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  request_t mem_req,
    output logic     req_grant,
    output request_t mem_rsp,
    input  logic     rsp_ready,
    output logic     init_done
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    mem_resp_state_t  state;
    logic [IDX_W-1:0] sweep_cnt;
    logic [63:0]      mem [MEM_DEPTH];

    request_t         head;
    request_t         rsp_next;
    request_t         stage_q [READ_LATENCY];
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             advance;
    logic [IDX_W-1:0] head_idx;
    logic             head_is_write;

    // Grant depends only on registered state, never on mem_req.
    assign req_grant     = init_done && (fifo_count != CNT_W'(FIFO_DEPTH));
    assign fifo_push     = mem_req.vld && req_grant && !fifo_full;
    assign advance       = !mem_rsp.vld || rsp_ready;
    assign fifo_pop      = !fifo_empty && advance;
    assign head_idx      = head.addr[IDX_W-1:0];
    assign head_is_write = (head.access_type == WRITE_REQ);
    assign mem_rsp       = stage_q[READ_LATENCY-1];

    vector_mem_req_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (mem_req),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= MR_INIT;
            sweep_cnt <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                MR_INIT: begin
                    sweep_cnt <= sweep_cnt + IDX_W'(1);
                    if (sweep_cnt == IDX_W'(MEM_DEPTH - 1)) begin
                        state     <= MR_READY;
                        init_done <= 1'b1;
                    end
                end
                MR_READY: begin
                    state <= MR_READY;
                end
            endcase
        end
    end

    // Writes commit at pop, so a read popped on the next cycle sees them.
    always_ff @(posedge clk) begin
        if (state == MR_INIT) begin
            mem[sweep_cnt] <= '0;
        end else if (fifo_pop && head_is_write) begin
            for (int b = 0; b < 8; b++) begin
                if (head.byte_en[b]) begin
                    mem[head_idx][b*8 +: 8] <= head.data[b*8 +: 8];
                end
            end
        end
    end

    // Unknown access types fall into the read branch but keep their original type.
    always_comb begin
        rsp_next = head;
        if (head_is_write) begin
            rsp_next.data = '0;
        end else begin
            rsp_next.data    = mem[head_idx];
            rsp_next.byte_en = 8'hff;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else if (advance) begin
            stage_q[0] <= fifo_pop ? rsp_next : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

endmodule

// File: doc/vector_mem_responder.md
Name: vector_mem_responder

Overview:
Memory-side responder for the vector load/store request protocol. It accepts `request_t` requests from one vector load/store unit under a valid/grant handshake and services them against a local banked word memory. It returns exactly one in-order `request_t` response per request: read data for loads, and a write acknowledge for stores. The block is the memory endpoint that load/store units target in unit tests and in the single-core configuration.

Parameters:
- MEM_DEPTH, 1024: number of 64-bit words; power of two.
- READ_LATENCY, 2: pipeline stages from request pop to response output; range 1 to 8.
- FIFO_DEPTH, 4: request FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- mem_req  input  request_t  request from the load/store unit; fields used: vld, access_type, access_length, access_id, core_id, addr, byte_en, data
- req_grant  output  1  request accepted when mem_req.vld && req_grant at a rising edge
- mem_rsp  output  request_t  response; vld qualifies the response
- rsp_ready  input  1  consumer can take the response this cycle; tie to 1 for consumers without backpressure
- init_done  output  1  memory zero-sweep complete; block is serviceable

Behaviour:
- Reset values: req_grant=0, mem_rsp='0, init_done=0, FIFO empty, all pipeline stages invalid, FSM in INIT, sweep counter 0.
- FSM, INIT state:
  - Writes 64'h0 to word[sweep_cnt] every cycle; sweep_cnt increments each cycle.
  - When sweep_cnt==MEM_DEPTH-1, the FSM moves to READY and init_done is set on the same edge.
  - INIT lasts exactly MEM_DEPTH cycles.
- FSM, READY state: terminal until reset.
- req_grant = init_done && (fifo_count != FIFO_DEPTH). It is derived from registered state only and has no combinational path from mem_req.
- Push: when mem_req.vld && req_grant, the full request struct is written to the FIFO.
- Advance: advance = !mem_rsp.vld || rsp_ready. When advance is 0, the whole pipeline holds; bubbles are not collapsed.
- Pop: fifo not empty && advance. The head enters stage 1. Push and pop in the same cycle leave fifo_count unchanged.
- Memory index is addr[$clog2(MEM_DEPTH)-1:0]; upper address bits are ignored, so accesses wrap modulo MEM_DEPTH.
- Read, at pop:
  - Stage 1 captures word[index].
  - Response: access_type=READ_REQ, data = the word, addr/access_id/core_id/access_length echoed, byte_en=8'hff.
- Write, at pop:
  - For each byte i with byte_en[i]=1, word[index] byte i <= data byte i.
  - Response: access_type=WRITE_REQ, data=0, other fields echoed.
- Ordering: commits happen in pop order. A read popped the cycle after a write to the same word returns the new data; there is no forwarding hazard.
- Pipeline: stages 1..READ_LATENCY; mem_rsp is the stage READ_LATENCY register.
- Latency: with the FIFO empty and rsp_ready=1, a request accepted at edge A is popped at edge A+1, and mem_rsp.vld is visible after edge A+READ_LATENCY.
- Throughput: 1 request per cycle sustained.
- Stall: when rsp_ready=0, mem_rsp holds stable (all fields). The FIFO keeps filling until full, then req_grant drops.
- Response count equals accepted-request count exactly; no drops, no duplicates.
- Reset mid-operation: the FIFO and pipeline flush, in-flight responses are lost, and INIT re-runs, zeroing the memory.
- Unknown access_type: treated as a read with no state change; the response echoes the original access_type.
- access_length: carried through only, never interpreted.

Decomposition:
- Shared design package (already home to request_t, READ_REQ, WRITE_REQ, REQUEST_COUNTER_WIDTH) gains:
  - MEM_RSP_LATENCY_DEFAULT.
  - A responder state enum, mem_resp_state_t: {MR_INIT, MR_READY}.
- Sub-module vector_mem_req_fifo:
  - Parameterised by FIFO_DEPTH; holds request_t entries.
  - Ports: push, pop, wdata, rdata, count, full, empty.
  - Also reused by the future multi-core arbiter.
- Memory array, FSM and pipeline stay in vector_mem_responder.

Test Plan:
- Init: after reset release, hold mem_req.vld=1 → req_grant=0 for MEM_DEPTH (1024) cycles; init_done and req_grant rise together; a read of addr 5 then returns data 0.
- Write/read: write addr 16, data 64'h1122334455667788, byte_en 8'hff, id 3, then read addr 16 with id 4 → WRITE_REQ ack with id 3, then READ_REQ rsp with data 64'h1122334455667788 and id 4, arriving 2 cycles after accept (READ_LATENCY=2).
- Partial bytes: preload addr 7 with 64'hFFFF_FFFF_FFFF_FFFF, write data 0 with byte_en 8'h0F, read → 64'hFFFF_FFFF_0000_0000.
- Back-to-back burst of 64 reads, addr 0..63, ids 0..63, rsp_ready=1 → req_grant stays 1, responses arrive on 64 consecutive cycles with ids 0..63 in order.
- Backpressure: rsp_ready=0 while 10 requests are offered → exactly FIFO_DEPTH+READ_LATENCY (6) are accepted before req_grant drops, and mem_rsp stays stable; on release, all 10 responses arrive in order with none lost.
- Wrap and reset: access addr MEM_DEPTH+3 → it aliases word 3. Assert reset with 3 requests in flight → mem_rsp.vld=0 immediately, no stale responses after re-init, and a read of word 3 returns 0.
